// File: rtl/eth_xcvr_link_mgr_if.sv
// Control/status bundle between the transceiver link manager and the shared-QPLL PHY wrappers.
// The master side is the link manager; the slave side is the PHY/SFP/LED fabric.
interface eth_xcvr_link_mgr_if #(
  parameter int unsigned CH_COUNT = 4,
  parameter int unsigned CNT_W    = 8
);
  logic [CH_COUNT-1:0]       ch_enable;
  logic                      qpll_lock;
  logic [CH_COUNT-1:0]       rx_block_lock;
  logic [CH_COUNT-1:0]       rx_high_ber;
  logic [CH_COUNT-1:0]       phy_rst;
  logic [CH_COUNT-1:0]       tx_disable_b;
  logic [CH_COUNT-1:0]       link_up;
  logic [CH_COUNT*CNT_W-1:0] retry_count;

  modport master (
    input  ch_enable, qpll_lock, rx_block_lock, rx_high_ber,
    output phy_rst, tx_disable_b, link_up, retry_count
  );

  modport slave (
    output ch_enable, qpll_lock, rx_block_lock, rx_high_ber,
    input  phy_rst, tx_disable_b, link_up, retry_count
  );
endinterface

// File: rtl/eth_xcvr_link_mgr.sv
// Per-channel bring-up and link supervisor for transceiver channels sharing one QPLL.
// Each channel sequences OFF -> RST -> WAIT -> UP with lock debounce, timeout retry and saturating retry count.
module eth_xcvr_link_mgr #(
  parameter int unsigned CH_COUNT      = 4,
  parameter int unsigned RST_CYCLES    = 64,
  parameter int unsigned LOCK_TIMEOUT  = 1 << 20,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned CNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  eth_xcvr_link_mgr_if.master bus
);
  localparam int unsigned TMR_MAX = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX) + 1;
  localparam int unsigned STB_W   = $clog2(STABLE_CYCLES) + 1;

  localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_LAST  = STB_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RETRY_MAX = '1;

  typedef enum logic [1:0] {ST_OFF, ST_RST, ST_WAIT, ST_UP} state_e;

  state_e            state_q  [CH_COUNT];
  state_e            state_d  [CH_COUNT];
  logic [TMR_W-1:0]  timer_q  [CH_COUNT];
  logic [TMR_W-1:0]  timer_d  [CH_COUNT];
  logic [STB_W-1:0]  stable_q [CH_COUNT];
  logic [STB_W-1:0]  stable_d [CH_COUNT];
  logic [CNT_W-1:0]  retry_q  [CH_COUNT];
  logic [CNT_W-1:0]  retry_d  [CH_COUNT];

  logic [CH_COUNT-1:0] phy_rst_q, phy_rst_d;
  logic [CH_COUNT-1:0] tx_disable_b_q, tx_disable_b_d;
  logic [CH_COUNT-1:0] link_up_q, link_up_d;
  logic [CH_COUNT-1:0] en_ok;
  logic [CH_COUNT-1:0] good;
  logic [CH_COUNT*CNT_W-1:0] retry_flat;

  assign en_ok = bus.ch_enable & {CH_COUNT{bus.qpll_lock}};
  assign good  = bus.rx_block_lock & ~bus.rx_high_ber;

  // Stable/timer terminal checks use the pre-increment value so the transition lands
  // on the same edge the counter would reach its terminal count.
  always_comb begin
    phy_rst_d      = '1;
    tx_disable_b_d = '0;
    link_up_d      = '0;
    for (int unsigned i = 0; i < CH_COUNT; i++) begin
      state_d[i]  = state_q[i];
      timer_d[i]  = timer_q[i];
      stable_d[i] = stable_q[i];
      retry_d[i]  = retry_q[i];
      if (!en_ok[i]) begin
        state_d[i]  = ST_OFF;
        timer_d[i]  = '0;
        stable_d[i] = '0;
      end else begin
        unique case (state_q[i])
          ST_OFF: begin
            state_d[i]  = ST_RST;
            timer_d[i]  = '0;
            stable_d[i] = '0;
          end
          ST_RST: begin
            if (timer_q[i] == RST_LAST) begin
              state_d[i] = ST_WAIT;
              timer_d[i] = '0;
            end else begin
              timer_d[i] = timer_q[i] + 1'b1;
            end
            stable_d[i] = '0;
          end
          ST_WAIT: begin
            timer_d[i]  = timer_q[i] + 1'b1;
            stable_d[i] = good[i] ? stable_q[i] + 1'b1 : '0;
            if (good[i] && (stable_q[i] == STB_LAST)) begin
              state_d[i]  = ST_UP;
              timer_d[i]  = '0;
              stable_d[i] = '0;
            end else if (timer_q[i] == WAIT_LAST) begin
              state_d[i]  = ST_RST;
              timer_d[i]  = '0;
              stable_d[i] = '0;
              if (retry_q[i] != RETRY_MAX) retry_d[i] = retry_q[i] + 1'b1;
            end
          end
          ST_UP: begin
            if (!good[i]) begin
              state_d[i]  = ST_WAIT;
              timer_d[i]  = '0;
              stable_d[i] = '0;
            end
          end
          default: state_d[i] = ST_OFF;
        endcase
      end
      phy_rst_d[i]      = (state_d[i] == ST_OFF) || (state_d[i] == ST_RST);
      tx_disable_b_d[i] = (state_d[i] != ST_OFF);
      link_up_d[i]      = (state_d[i] == ST_UP);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CH_COUNT; i++) begin
        state_q[i]  <= ST_OFF;
        timer_q[i]  <= '0;
        stable_q[i] <= '0;
        retry_q[i]  <= '0;
      end
      phy_rst_q      <= '1;
      tx_disable_b_q <= '0;
      link_up_q      <= '0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      stable_q       <= stable_d;
      retry_q        <= retry_d;
      phy_rst_q      <= phy_rst_d;
      tx_disable_b_q <= tx_disable_b_d;
      link_up_q      <= link_up_d;
    end
  end

  always_comb begin
    retry_flat = '0;
    for (int unsigned i = 0; i < CH_COUNT; i++) begin
      retry_flat[i*CNT_W +: CNT_W] = retry_q[i];
    end
  end

  assign bus.phy_rst      = phy_rst_q;
  assign bus.tx_disable_b = tx_disable_b_q;
  assign bus.link_up      = link_up_q;
  assign bus.retry_count  = retry_flat;
endmodule

// File: tb/tb_eth_xcvr_link_mgr.sv
// Scoreboard bench for eth_xcvr_link_mgr: stimulus queues expected outputs tagged with a cycle number,
// a negedge monitor pops and compares entries when their cycle arrives.
module tb_eth_xcvr_link_mgr;
  logic clk = 1'b0;
  logic rst_n;
  int unsigned cyc = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    int unsigned cyc;
    string       name;
    logic [3:0]  phy;
    logic [3:0]  txd;
    logic [3:0]  lu;
    logic [15:0] rc;
  } exp_t;

  exp_t sb[$];

  eth_xcvr_link_mgr_if #(.CH_COUNT(4), .CNT_W(4)) bus_if ();

  eth_xcvr_link_mgr #(
    .CH_COUNT     (4),
    .RST_CYCLES   (8),
    .LOCK_TIMEOUT (100),
    .STABLE_CYCLES(16),
    .CNT_W        (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected outputs after n more rising edges from now.
  task automatic push_exp(input int unsigned n, input string name, input logic [3:0] phy,
                          input logic [3:0] txd, input logic [3:0] lu, input logic [15:0] rc);
    exp_t e;
    e.cyc  = cyc + n;
    e.name = name;
    e.phy  = phy;
    e.txd  = txd;
    e.lu   = lu;
    e.rc   = rc;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        total++;
        if (sb[i].cyc < cyc) begin
          bad++;
          $display("FAIL %s: checked at cyc %0d, required at cyc %0d", sb[i].name, cyc, sb[i].cyc);
        end else if (bus_if.phy_rst !== sb[i].phy || bus_if.tx_disable_b !== sb[i].txd ||
                     bus_if.link_up !== sb[i].lu || bus_if.retry_count !== sb[i].rc) begin
          bad++;
          $display("FAIL %s cyc=%0d: got phy_rst=%h tx_disable_b=%h link_up=%h retry=%h, want phy_rst=%h tx_disable_b=%h link_up=%h retry=%h",
                   sb[i].name, cyc, bus_if.phy_rst, bus_if.tx_disable_b, bus_if.link_up,
                   bus_if.retry_count, sb[i].phy, sb[i].txd, sb[i].lu, sb[i].rc);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    rst_n                = 1'b0;
    bus_if.ch_enable     = 4'h0;
    bus_if.qpll_lock     = 1'b0;
    bus_if.rx_block_lock = 4'h0;
    bus_if.rx_high_ber   = 4'h0;
    step(2);
    push_exp(0, "reset", 4'hF, 4'h0, 4'h0, 16'h0000);

    // Bring up channel 0 only
    rst_n                = 1'b1;
    bus_if.ch_enable     = 4'h1;
    bus_if.qpll_lock     = 1'b1;
    bus_if.rx_block_lock = 4'h1;
    push_exp(1,  "rst_enter",  4'hF, 4'h1, 4'h0, 16'h0000);
    push_exp(8,  "rst_last",   4'hF, 4'h1, 4'h0, 16'h0000);
    push_exp(9,  "wait_enter", 4'hE, 4'h1, 4'h0, 16'h0000);
    push_exp(24, "pre_up",     4'hE, 4'h1, 4'h0, 16'h0000);
    push_exp(25, "up",         4'hE, 4'h1, 4'h1, 16'h0000);
    step(25);

    // One-cycle high BER while up
    bus_if.rx_high_ber = 4'h1;
    push_exp(1,  "ber_drop", 4'hE, 4'h1, 4'h0, 16'h0000);
    push_exp(16, "ber_pre",  4'hE, 4'h1, 4'h0, 16'h0000);
    push_exp(17, "ber_up",   4'hE, 4'h1, 4'h1, 16'h0000);
    step(1);
    bus_if.rx_high_ber = 4'h0;
    step(16);

    // Lock glitch during debounce restarts the stable count
    bus_if.rx_block_lock = 4'h0;
    push_exp(1,  "lock_drop",  4'hE, 4'h1, 4'h0, 16'h0000);
    push_exp(11, "glitch_mid", 4'hE, 4'h1, 4'h0, 16'h0000);
    step(1);
    bus_if.rx_block_lock = 4'h1;
    step(10);
    bus_if.rx_block_lock = 4'h0;
    step(1);
    bus_if.rx_block_lock = 4'h1;
    push_exp(15, "glitch_pre", 4'hE, 4'h1, 4'h0, 16'h0000);
    push_exp(16, "glitch_up",  4'hE, 4'h1, 4'h1, 16'h0000);
    step(16);

    // Lock lost forever: timeout retries and saturation
    bus_if.rx_block_lock = 4'h0;
    push_exp(1,    "lose_lock",   4'hE, 4'h1, 4'h0, 16'h0000);
    push_exp(100,  "timeout_pre", 4'hE, 4'h1, 4'h0, 16'h0000);
    push_exp(101,  "retry1",      4'hF, 4'h1, 4'h0, 16'h0001);
    push_exp(108,  "retry1_rst",  4'hF, 4'h1, 4'h0, 16'h0001);
    push_exp(109,  "retry1_wait", 4'hE, 4'h1, 4'h0, 16'h0001);
    push_exp(209,  "retry2",      4'hF, 4'h1, 4'h0, 16'h0002);
    push_exp(1613, "retry15",     4'hF, 4'h1, 4'h0, 16'h000F);
    push_exp(1721, "retry_sat",   4'hF, 4'h1, 4'h0, 16'h000F);
    push_exp(1729, "sat_wait",    4'hE, 4'h1, 4'h0, 16'h000F);
    step(1730);

    // All channels up
    bus_if.ch_enable     = 4'hF;
    bus_if.rx_block_lock = 4'hF;
    push_exp(1,  "all_en",   4'hE, 4'hF, 4'h0, 16'h000F);
    push_exp(9,  "all_wait", 4'h0, 4'hF, 4'h0, 16'h000F);
    push_exp(16, "ch0_up",   4'h0, 4'hF, 4'h1, 16'h000F);
    push_exp(24, "ch0_only", 4'h0, 4'hF, 4'h1, 16'h000F);
    push_exp(25, "all_up",   4'h0, 4'hF, 4'hF, 16'h000F);
    step(25);

    // QPLL loss forces every channel off, retry count held
    bus_if.qpll_lock = 1'b0;
    push_exp(1, "qpll_drop", 4'hF, 4'h0, 4'h0, 16'h000F);
    push_exp(4, "qpll_hold", 4'hF, 4'h0, 4'h0, 16'h000F);
    step(4);

    // Restore with staggered block lock
    bus_if.qpll_lock     = 1'b1;
    bus_if.rx_block_lock = 4'h0;
    push_exp(1,  "relock_rst",  4'hF, 4'hF, 4'h0, 16'h000F);
    push_exp(9,  "relock_wait", 4'h0, 4'hF, 4'h0, 16'h000F);
    push_exp(25, "stag_ch0",    4'h0, 4'hF, 4'h1, 16'h000F);
    push_exp(27, "stag_ch1pre", 4'h0, 4'hF, 4'h1, 16'h000F);
    push_exp(28, "stag_ch1",    4'h0, 4'hF, 4'h3, 16'h000F);
    push_exp(31, "stag_ch2",    4'h0, 4'hF, 4'h7, 16'h000F);
    push_exp(35, "stag_ch3pre", 4'h0, 4'hF, 4'h7, 16'h000F);
    push_exp(36, "stag_ch3",    4'h0, 4'hF, 4'hF, 16'h000F);
    step(9);
    bus_if.rx_block_lock = 4'h1;
    step(3);
    bus_if.rx_block_lock = 4'h3;
    step(3);
    bus_if.rx_block_lock = 4'h7;
    step(5);
    bus_if.rx_block_lock = 4'hF;
    step(16);

    // Reset while all up clears retry count
    rst_n = 1'b0;
    push_exp(1, "rst_all",  4'hF, 4'h0, 4'h0, 16'h0000);
    push_exp(2, "rst_hold", 4'hF, 4'h0, 4'h0, 16'h0000);
    step(2);

    // Build up three retries on ch0, then reset mid-WAIT
    rst_n                = 1'b1;
    bus_if.ch_enable     = 4'h1;
    bus_if.rx_block_lock = 4'h0;
    push_exp(325, "r3_rst",  4'hF, 4'h1, 4'h0, 16'h0003);
    push_exp(333, "r3_wait", 4'hE, 4'h1, 4'h0, 16'h0003);
    step(340);
    rst_n = 1'b0;
    push_exp(1, "rst_in_wait", 4'hF, 4'h0, 4'h0, 16'h0000);
    step(1);
    rst_n            = 1'b1;
    bus_if.ch_enable = 4'h0;
    push_exp(2, "disabled_after_rst", 4'hF, 4'h0, 4'h0, 16'h0000);
    step(3);

    for (int k = 0; k < 8 && sb.size() != 0; k++) step(1);
    while (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s: never checked, required at cyc %0d", sb[0].name, sb[0].cyc);
      sb.delete(0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
